clock_calendar_ctrl: RTL and testbench

- Sequencer for the digital clock/calendar datapath.
- Divides the system clock into a 1 Hz tick and cascades seconds -> minutes -> hours -> day -> month -> year, with month-length and leap-year rules.
- Runs a set-mode FSM driven by two pre-debounced button pulses.
- Sits between the button front-end and the 7-segment display mux; all time/date registers live here.

---
 rtl/clock_calendar_ctrl_if.sv | 24 ++
 rtl/clock_calendar_ctrl.sv | 148 ++++++++++++++
 tb/tb_clock_calendar_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_calendar_ctrl_if.sv
// Button inputs and time/date outputs of the clock/calendar sequencer.
// master = button front-end / display side, slave = the sequencer itself.
interface clock_calendar_ctrl_if;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [2:0] mode;
    logic       sec_tick;

    modport master (
        output mode_btn, inc_btn,
        input  sec, min, hour, day, month, year, mode, sec_tick
    );

    modport slave (
        input  mode_btn, inc_btn,
        output sec, min, hour, day, month, year, mode, sec_tick
    );
endinterface

// File: rtl/clock_calendar_ctrl.sv
// Digital clock/calendar sequencer: 1 Hz prescaler, single-edge time/date cascade
// with month-length and leap-year rules, and a button-driven set-mode FSM.
module clock_calendar_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clock_calendar_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_DAY = 3'd3,
        SET_MON = 3'd4,
        SET_YR  = 3'd5
    } mode_t;

    mode_t         mode_q;
    mode_t         mode_nxt;
    logic [PW-1:0] presc_q;
    logic [5:0]    sec_q;
    logic [5:0]    min_q;
    logic [4:0]    hour_q;
    logic [4:0]    day_q;
    logic [3:0]    month_q;
    logic [6:0]    year_q;
    logic          tick_q;

    logic          tick;
    logic          sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;
    logic          c_min, c_hour, c_day, c_mon, c_yr;
    logic [5:0]    sec_inc, min_inc;
    logic [4:0]    hour_inc, day_inc;
    logic [3:0]    mon_inc;
    logic [6:0]    yr_inc;
    logic [4:0]    dim_cur, dim_mon, dim_yr;

    // Only the two low year bits matter: every fourth year of 2000-2099 is leap.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [1:0] y_lsb);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = (y_lsb == 2'd0) ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    always_comb begin
        tick      = (mode_q == RUN) && (presc_q == PRESC_MAX);

        dim_cur   = days_in_month(month_q, year_q[1:0]);
        sec_wrap  = (sec_q == 6'd59);
        min_wrap  = (min_q == 6'd59);
        hour_wrap = (hour_q == 5'd23);
        day_wrap  = (day_q == dim_cur);
        mon_wrap  = (month_q == 4'd12);

        sec_inc   = sec_wrap  ? 6'd0 : sec_q + 6'd1;
        min_inc   = min_wrap  ? 6'd0 : min_q + 6'd1;
        hour_inc  = hour_wrap ? 5'd0 : hour_q + 5'd1;
        day_inc   = day_wrap  ? 5'd1 : day_q + 5'd1;
        mon_inc   = mon_wrap  ? 4'd1 : month_q + 4'd1;
        yr_inc    = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;

        // Month lengths after a month or year edit, used to clamp the day.
        dim_mon   = days_in_month(mon_inc, year_q[1:0]);
        dim_yr    = days_in_month(month_q, yr_inc[1:0]);

        // Full carry chain is resolved combinationally so everything lands on one edge.
        c_min     = tick && sec_wrap;
        c_hour    = c_min && min_wrap;
        c_day     = c_hour && hour_wrap;
        c_mon     = c_day && day_wrap;
        c_yr      = c_mon && mon_wrap;

        case (mode_q)
            RUN:     mode_nxt = SET_HR;
            SET_HR:  mode_nxt = SET_MIN;
            SET_MIN: mode_nxt = SET_DAY;
            SET_DAY: mode_nxt = SET_MON;
            SET_MON: mode_nxt = SET_YR;
            default: mode_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= RUN;
            presc_q <= '0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 5'd0;
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= 7'd0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            // mode_btn takes priority over both the tick and any edit in the same cycle.
            if (bus.mode_btn) begin
                mode_q  <= mode_nxt;
                presc_q <= '0;
                if (mode_q == SET_YR) begin
                    sec_q <= 6'd0;
                end
            end else if (mode_q == RUN) begin
                presc_q <= tick ? '0 : presc_q + PRESC_ONE;
                if (tick) begin
                    tick_q <= 1'b1;
                    sec_q  <= sec_inc;
                end
                if (c_min)  min_q   <= min_inc;
                if (c_hour) hour_q  <= hour_inc;
                if (c_day)  day_q   <= day_inc;
                if (c_mon)  month_q <= mon_inc;
                if (c_yr)   year_q  <= yr_inc;
            end else if (bus.inc_btn) begin
                case (mode_q)
                    SET_HR:  hour_q <= hour_inc;
                    SET_MIN: min_q  <= min_inc;
                    SET_DAY: day_q  <= day_inc;
                    SET_MON: begin
                        month_q <= mon_inc;
                        if (day_q > dim_mon) day_q <= dim_mon;
                    end
                    SET_YR: begin
                        year_q <= yr_inc;
                        if (day_q > dim_yr) day_q <= dim_yr;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.day      = day_q;
    assign bus.month    = month_q;
    assign bus.year     = year_q;
    assign bus.mode     = mode_q;
    assign bus.sec_tick = tick_q;
endmodule

// File: tb/tb_clock_calendar_ctrl.sv
// Directed bench for clock_calendar_ctrl with TICK_DIV=4: rollovers, leap Feb,
// set-mode editing and clamp, button priority, exit timing and async reset.
`timescale 1ns/1ps
module tb_clock_calendar_ctrl;
    localparam int TICK_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   set_tick_seen = 0;

    clock_calendar_ctrl_if bus ();

    clock_calendar_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // sec_tick must never be seen while the FSM sits in a SET state.
    always @(negedge clk) begin
        if (rst_n && bus.mode != 3'd0 && bus.sec_tick) set_tick_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s,
                            input int d, input int mo, input int y);
        chk({tag, " hour"},  int'(bus.hour),  h);
        chk({tag, " min"},   int'(bus.min),   m);
        chk({tag, " sec"},   int'(bus.sec),   s);
        chk({tag, " day"},   int'(bus.day),   d);
        chk({tag, " month"}, int'(bus.month), mo);
        chk({tag, " year"},  int'(bus.year),  y);
    endtask

    task automatic do_reset();
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_mode(input int n);
        repeat (n) begin
            @(negedge clk); bus.mode_btn = 1'b1;
            @(negedge clk); bus.mode_btn = 1'b0;
        end
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            @(negedge clk); bus.inc_btn = 1'b1;
            @(negedge clk); bus.inc_btn = 1'b0;
        end
    endtask

    task automatic run_secs(input int n);
        repeat (n * TICK_DIV) @(negedge clk);
    endtask

    // From reset: set hour/min, then month before year, then day last so no clamp
    // interferes; exits in RUN with sec=0 and prescaler=0.
    task automatic set_time(input int h, input int m, input int d, input int mo, input int y);
        do_reset();
        pulse_mode(1); pulse_inc(h);
        pulse_mode(1); pulse_inc(m);
        pulse_mode(2); pulse_inc(mo - 1);
        pulse_mode(1); pulse_inc(y);
        pulse_mode(1);
        pulse_mode(3); pulse_inc(d - 1);
        pulse_mode(3);
    endtask

    // Advance to hh:mm:59, then check the following tick lands the expected date.
    task automatic rollover(input string tag, input int h0, input int m0, input int d0,
                            input int mo0, input int y0, input int d1, input int mo1, input int y1);
        run_secs(59);
        chk_time({tag, " pre"}, h0, m0, 59, d0, mo0, y0);
        repeat (TICK_DIV - 1) @(negedge clk);
        chk({tag, " no early tick"}, int'(bus.sec_tick), 0);
        @(negedge clk);
        chk({tag, " tick"}, int'(bus.sec_tick), 1);
        chk_time({tag, " post"}, 0, 0, 0, d1, mo1, y1);
        @(negedge clk);
        chk({tag, " tick one cycle"}, int'(bus.sec_tick), 0);
    endtask

    initial begin
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;

        // Reset values while rst_n held low.
        repeat (2) @(negedge clk);
        chk_time("reset", 0, 0, 0, 1, 1, 0);
        chk("reset mode", int'(bus.mode), 0);
        chk("reset sec_tick", int'(bus.sec_tick), 0);
        rst_n = 1'b1;

        // Year wrap.
        set_time(23, 59, 31, 12, 99);
        rollover("yearwrap", 23, 59, 31, 12, 99, 1, 1, 0);

        // Leap and non-leap February.
        set_time(23, 59, 28, 2, 24);
        rollover("leap28", 23, 59, 28, 2, 24, 29, 2, 24);
        set_time(23, 59, 29, 2, 24);
        rollover("leap29", 23, 59, 29, 2, 24, 1, 3, 24);
        set_time(23, 59, 28, 2, 23);
        rollover("noleap28", 23, 59, 28, 2, 23, 1, 3, 23);

        // Day editing wrap and month/year clamp.
        do_reset();
        pulse_mode(3);
        chk("setday mode", int'(bus.mode), 3);
        pulse_inc(30);
        chk("setday 31", int'(bus.day), 31);
        pulse_inc(1);
        chk("setday wrap", int'(bus.day), 1);
        pulse_inc(30);
        pulse_mode(1);
        chk("setmon mode", int'(bus.mode), 4);
        pulse_inc(1);
        chk("clamp mon month", int'(bus.month), 2);
        chk("clamp mon day", int'(bus.day), 29);
        pulse_mode(1);
        pulse_inc(1);
        chk("clamp yr year", int'(bus.year), 1);
        chk("clamp yr day", int'(bus.day), 28);
        chk("clamp yr month", int'(bus.month), 2);

        // Simultaneous pulses and inc in RUN.
        do_reset();
        pulse_mode(1);
        pulse_inc(5);
        chk("sethr 5", int'(bus.hour), 5);
        @(negedge clk); bus.mode_btn = 1'b1; bus.inc_btn = 1'b1;
        @(negedge clk); bus.mode_btn = 1'b0; bus.inc_btn = 1'b0;
        chk("both mode", int'(bus.mode), 2);
        chk("both hour", int'(bus.hour), 5);
        pulse_mode(4);
        chk("back to run", int'(bus.mode), 0);
        pulse_inc(1);
        chk_time("inc in run", 5, 0, 0, 1, 1, 0);

        // Exit timing from SET_YR.
        do_reset();
        run_secs(37);
        chk("run 37", int'(bus.sec), 37);
        pulse_mode(1);
        chk("enter set mode", int'(bus.mode), 1);
        repeat (10) @(negedge clk);
        chk("sec frozen", int'(bus.sec), 37);
        pulse_mode(4);
        chk("setyr sec", int'(bus.sec), 37);
        pulse_mode(1);
        chk("exit mode", int'(bus.mode), 0);
        chk("exit sec", int'(bus.sec), 0);
        for (int i = 1; i < TICK_DIV; i++) begin
            @(negedge clk);
            chk($sformatf("exit no tick c%0d", i), int'(bus.sec_tick), 0);
        end
        @(negedge clk);
        chk("exit first tick", int'(bus.sec_tick), 1);
        chk("exit first sec", int'(bus.sec), 1);

        // Asynchronous reset mid-set.
        do_reset();
        pulse_mode(4);
        pulse_inc(6);
        chk("midset month", int'(bus.month), 7);
        chk("midset mode", int'(bus.mode), 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_time("async reset", 0, 0, 0, 1, 1, 0);
        chk("async reset mode", int'(bus.mode), 0);
        chk("async reset tick", int'(bus.sec_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after release mode", int'(bus.mode), 0);
        chk("after release month", int'(bus.month), 1);

        chk("sec_tick in set states", set_tick_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
